axi_slave_mem: RTL and testbench

// Parametrised AXI4 memory slave, successor to the fixed-width axi_slave; it plugs into the same top/axi_intf bench.

---
 rtl/axi_slave_mem.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem.sv
// AXI4 memory slave with independent write and read channel FSMs.
// Supports FIXED/INCR/WRAP bursts, byte strobes and SLVERR on out-of-range or illegal bursts.
module axi_slave_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 1024
) (
  input  logic                aclk,
  input  logic                arst,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int BYTES   = DATA_W / 8;
  localparam int LSB     = $clog2(BYTES);
  localparam int DEPTH_W = $clog2(DEPTH);

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [7:0]        len,
                                                  input logic [1:0]        burst);
    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] mask;
    inc  = addr + ADDR_W'(BYTES);
    mask = ADDR_W'((32'(len) + 32'd1) * 32'(BYTES) - 32'd1);
    case (burst)
      BURST_INCR: return inc;
      BURST_WRAP: return (addr & ~mask) | (inc & mask);
      default:    return addr;
    endcase
  endfunction

  function automatic logic burst_illegal(input logic [7:0] len, input logic [1:0] burst);
    return (burst == BURST_RSVD) ||
           ((burst == BURST_WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
    return 32'(addr >> LSB) < 32'(DEPTH);
  endfunction

  function automatic logic [DEPTH_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    return DEPTH_W'(addr >> LSB);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  // ---------------- write channel ----------------
  w_state_e          w_state_q, w_state_d;
  logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [ID_W-1:0]   bid_q, bid_d;
  logic [1:0]        bresp_q, bresp_d, w_burst_q, w_burst_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [7:0]        w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic              w_err_q, w_err_d;
  logic              w_hs, w_last_beat, w_ok, w_beat_err;

  assign w_hs        = (w_state_q == W_DATA) && wvalid && wready_q;
  assign w_last_beat = (w_cnt_q == w_len_q);
  assign w_ok        = !burst_illegal(w_len_q, w_burst_q) && addr_ok(w_addr_q);
  // The beat counter ends the burst; a misplaced wlast only taints the response.
  assign w_beat_err  = !w_ok || (wlast != w_last_beat);

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_burst_d = w_burst_q;
    w_cnt_d   = w_cnt_q;
    w_err_d   = w_err_q;
    unique case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (awvalid && awready_q) begin
          bid_d     = awid;
          w_addr_d  = awaddr;
          w_len_d   = awlen;
          w_burst_d = awburst;
          w_cnt_d   = '0;
          w_err_d   = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          w_addr_d = next_addr(w_addr_q, w_len_q, w_burst_q);
          w_cnt_d  = w_cnt_q + 8'd1;
          w_err_d  = w_err_q || w_beat_err;
          if (w_last_beat) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = (w_err_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (bready && bvalid_q) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge arst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!arst) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_burst_q <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_burst_q <= w_burst_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
    end
  end

  // NOTE: the storage array has no reset; contents survive arst and map onto plain RAM.
  always_ff @(posedge aclk) begin
    if (w_hs && w_ok) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb[b]) mem[word_idx(w_addr_q)][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_e          r_state_q, r_state_d;
  logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [1:0]        rresp_q, rresp_d, r_burst_q, r_burst_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, r_word;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d, r_src_addr;
  logic [7:0]        r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic              r_src_ok;

  // The first beat comes straight from the AR channel, later beats from the burst registers.
  always_comb begin
    if (r_state_q == R_IDLE) begin
      r_src_addr = araddr;
      r_src_ok   = !burst_illegal(arlen, arburst) && addr_ok(araddr);
    end else begin
      r_src_addr = r_addr_q;
      r_src_ok   = !burst_illegal(r_len_q, r_burst_q) && addr_ok(r_addr_q);
    end
    r_word = r_src_ok ? mem[word_idx(r_src_addr)] : '0;
  end

  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_burst_d = r_burst_q;
    r_cnt_d   = r_cnt_q;
    unique case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arvalid && arready_q) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rid_d     = arid;
          rdata_d   = r_word;
          rresp_d   = r_src_ok ? RESP_OKAY : RESP_SLVERR;
          rlast_d   = (arlen == 8'd0);
          r_addr_d  = next_addr(araddr, arlen, arburst);
          r_len_d   = arlen;
          r_burst_d = arburst;
          r_cnt_d   = '0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_q && rready) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            rdata_d  = r_word;
            rresp_d  = r_src_ok ? RESP_OKAY : RESP_SLVERR;
            rlast_d  = ((r_cnt_q + 8'd1) == r_len_q);
            r_cnt_d  = r_cnt_q + 8'd1;
            r_addr_d = next_addr(r_addr_q, r_len_q, r_burst_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge arst) begin
    if (!arst) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_burst_q <= '0;
      r_cnt_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_burst_q <= r_burst_d;
      r_cnt_q   <= r_cnt_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: table of read bursts plus hand-written
// sequences for strobes, wlast errors, back-pressure, concurrency and mid-burst reset.
module tb_axi_slave_mem;

  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] WRAP   = 2'b10;
  localparam logic [1:0] RSVD   = 2'b11;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [31:0] WORD0 = 32'hCAFE_0001;

  logic        aclk = 1'b0;
  logic        arst = 1'b0;
  logic [3:0]  awid = '0, arid = '0, bid, rid;
  logic [15:0] awaddr = '0, araddr = '0;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
  logic        awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
  logic        arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid, rlast;
  logic [31:0] wdata = '0, rdata;
  logic [3:0]  wstrb = '0;

  axi_slave_mem dut (
    .aclk(aclk), .arst(arst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [31:0] exp_data [4];
    logic [1:0]  exp_resp [4];
  } rd_vec_t;

  localparam int NVEC = 11;
  rd_vec_t vecs [NVEC];

  function automatic rd_vec_t mk(input logic [15:0] a, input logic [7:0] l, input logic [1:0] b,
                                 input logic [31:0] d0, input logic [31:0] d1,
                                 input logic [31:0] d2, input logic [31:0] d3,
                                 input logic [1:0] r0, input logic [1:0] r1,
                                 input logic [1:0] r2, input logic [1:0] r3);
    rd_vec_t v;
    v.addr = a; v.len = l; v.burst = b;
    v.exp_data[0] = d0; v.exp_data[1] = d1; v.exp_data[2] = d2; v.exp_data[3] = d3;
    v.exp_resp[0] = r0; v.exp_resp[1] = r1; v.exp_resp[2] = r2; v.exp_resp[3] = r3;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [15:0] last_mask, input int b_stall,
                          output logic [1:0] resp);
    int n;
    bit stable;
    logic [1:0] r0;
    resp = 2'b11;
    awid = 4'hA; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge aclk); n++; end
    if (!awready) begin awvalid = 1'b0; timeout_fail("aw_handshake"); return; end
    @(negedge aclk);
    awvalid = 1'b0;
    check("w_turnaround", wready, 1);
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wd[i]; wstrb = ws[i]; wlast = last_mask[i]; wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin @(negedge aclk); n++; end
      if (!wready) begin wvalid = 1'b0; timeout_fail("w_handshake"); return; end
      @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("b_latency", bvalid, 1);
    if (b_stall > 0) begin
      r0 = bresp;
      stable = 1'b1;
      repeat (b_stall) begin
        @(negedge aclk);
        if (!bvalid || bresp !== r0) stable = 1'b0;
      end
      check("b_hold_stable", stable, 1);
    end
    n = 0;
    while (!bvalid && n < 50) begin @(negedge aclk); n++; end
    if (!bvalid) begin timeout_fail("b_handshake"); return; end
    resp = bresp;
    check("b_bid", bid, 4'hA);
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    check("b_end_idle", {bvalid, awready}, 2'b01);
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input int stall_at);
    int n;
    bit bubble, stable;
    logic [31:0] d0;
    logic [1:0] r0;
    logic l0;
    bubble = 1'b0;
    arid = 4'h6; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge aclk); n++; end
    if (!arready) begin arvalid = 1'b0; timeout_fail("ar_handshake"); return; end
    @(negedge aclk);
    arvalid = 1'b0;
    check("r_latency", rvalid, 1);
    for (int i = 0; i <= int'(len); i++) begin
      if (i > 0 && !rvalid) bubble = 1'b1;
      n = 0;
      while (!rvalid && n < 50) begin @(negedge aclk); n++; end
      if (!rvalid) begin timeout_fail("r_beat"); return; end
      if (i == stall_at) begin
        d0 = rdata; r0 = rresp; l0 = rlast;
        stable = 1'b1;
        repeat (5) begin
          @(negedge aclk);
          if (!rvalid || rdata !== d0 || rresp !== r0 || rlast !== l0) stable = 1'b0;
        end
        check("r_stall_stable", stable, 1);
      end
      rd_data[i] = rdata; rd_resp[i] = rresp; rd_last[i] = rlast;
      if (i == 0) check("r_rid", rid, 4'h6);
      rready = 1'b1;
      @(negedge aclk);
      rready = 1'b0;
    end
    if (stall_at < 0) check("r_no_bubble", bubble, 0);
    check("r_end_idle", {rvalid, arready}, 2'b01);
  endtask

  logic [1:0] resp, resp2;
  bit seen_b;

  initial begin
    // Expected read-back after all setup writes below have completed.
    vecs[0]  = mk(16'h0010, 3, INCR,  32'hA0, 32'hA1, 32'hA2, 32'hA3, OKAY, OKAY, OKAY, OKAY);
    vecs[1]  = mk(16'h0038, 3, WRAP,  32'hC2, 32'hC3, 32'hC0, 32'hC1, OKAY, OKAY, OKAY, OKAY);
    vecs[2]  = mk(16'h0014, 2, FIXED, 32'hA1, 32'hA1, 32'hA1, 0, OKAY, OKAY, OKAY, OKAY);
    vecs[3]  = mk(16'h0018, 0, INCR,  32'hA2, 0, 0, 0, OKAY, OKAY, OKAY, OKAY);
    vecs[4]  = mk(16'h0014, 1, WRAP,  32'hA1, 32'hA0, 0, 0, OKAY, OKAY, OKAY, OKAY);
    vecs[5]  = mk(16'h0010, 2, WRAP,  0, 0, 0, 0, SLVERR, SLVERR, SLVERR, OKAY);
    vecs[6]  = mk(16'h1000, 0, INCR,  0, 0, 0, 0, SLVERR, OKAY, OKAY, OKAY);
    vecs[7]  = mk(16'h0010, 0, RSVD,  0, 0, 0, 0, SLVERR, OKAY, OKAY, OKAY);
    vecs[8]  = mk(16'hFFFC, 1, INCR,  0, WORD0, 0, 0, SLVERR, OKAY, OKAY, OKAY);
    vecs[9]  = mk(16'h0020, 0, INCR,  32'h2222_2233, 0, 0, 0, OKAY, OKAY, OKAY, OKAY);
    vecs[10] = mk(16'h0040, 2, INCR,  32'h4040_4040, 32'h4444_4444, 32'h4848_4848, 0,
                  OKAY, OKAY, OKAY, OKAY);

    arst = 1'b0;
    repeat (3) @(negedge aclk);
    check("rst_valids_readys", {awready, wready, bvalid, arready, rvalid, rlast}, 6'b0);
    check("rst_resp_data", {bresp, rresp, rdata}, 36'b0);
    arst = 1'b1;
    #1 check("rst_release_awready_low", awready, 0);
    @(negedge aclk);
    check("rst_release_readys_high", {awready, arready}, 2'b11);

    for (int i = 0; i < 16; i++) ws[i] = 4'hF;

    for (int i = 0; i < 4; i++) wd[i] = 32'hA0 + i;
    do_write(16'h0010, 3, INCR, 16'h0008, 0, resp);
    check("wr_incr_A_bresp", resp, OKAY);

    for (int i = 0; i < 4; i++) wd[i] = 32'hC0 + i;
    do_write(16'h0030, 3, INCR, 16'h0008, 0, resp);
    check("wr_incr_C_bresp", resp, OKAY);

    wd[0] = 32'h1111_1111; wd[1] = 32'h2222_2222; wd[2] = 32'h3333_3333;
    ws[2] = 4'h1;
    do_write(16'h0020, 2, FIXED, 16'h0004, 0, resp);
    check("wr_fixed_strb_bresp", resp, OKAY);
    ws[2] = 4'hF;

    wd[0] = 32'hDEAD_0000; wd[1] = WORD0;
    do_write(16'hFFFC, 1, INCR, 16'h0002, 0, resp);
    check("wr_addr_wrap_oor_bresp", resp, SLVERR);

    wd[0] = 32'hDEAD_BEEF;
    do_write(16'h1000, 0, INCR, 16'h0001, 0, resp);
    check("wr_oor_bresp", resp, SLVERR);

    wd[0] = 32'h4040_4040; wd[1] = 32'h4444_4444;
    do_write(16'h0040, 1, INCR, 16'h0001, 0, resp);
    check("wr_wlast_early_bresp", resp, SLVERR);

    wd[0] = 32'h4848_4848;
    do_write(16'h0048, 0, INCR, 16'h0000, 0, resp);
    check("wr_wlast_missing_bresp", resp, SLVERR);

    for (int k = 0; k < NVEC; k++) begin
      do_read(vecs[k].addr, vecs[k].len, vecs[k].burst, -1);
      for (int i = 0; i <= int'(vecs[k].len); i++) begin
        check($sformatf("vec%0d_beat%0d_data", k, i), rd_data[i], vecs[k].exp_data[i]);
        check($sformatf("vec%0d_beat%0d_resp", k, i), rd_resp[i], vecs[k].exp_resp[i]);
        check($sformatf("vec%0d_beat%0d_last", k, i), rd_last[i], (i == int'(vecs[k].len)));
      end
    end

    do_read(16'h0010, 3, INCR, 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall_beat%0d_data", i), rd_data[i], 32'hA0 + i);
      check($sformatf("stall_beat%0d_last", i), rd_last[i], (i == 3));
    end

    wd[0] = 32'h5858_5858;
    do_write(16'h0058, 0, INCR, 16'h0001, 3, resp);
    check("wr_bstall_bresp", resp, OKAY);
    do_read(16'h0058, 0, INCR, -1);
    check("rd_bstall_data", rd_data[0], 32'h5858_5858);

    wd[0] = 32'h5050_5050;
    do_write(16'h0050, 0, INCR, 16'h0001, 0, resp);
    wd[0] = 32'h5555_5555;
    fork
      do_write(16'h0050, 0, INCR, 16'h0001, 0, resp2);
      do_read(16'h0050, 0, INCR, -1);
    join
    check("concurrent_bresp", resp2, OKAY);
    check("concurrent_read_old", rd_data[0], 32'h5050_5050);
    do_read(16'h0050, 0, INCR, -1);
    check("concurrent_read_new", rd_data[0], 32'h5555_5555);

    for (int i = 0; i < 4; i++) wd[i] = 32'hE0 + i;
    awid = 4'hA; awaddr = 16'h0070; awlen = 3; awburst = INCR; awvalid = 1'b1;
    check("rst_mid_aw_ready", awready, 1);
    @(negedge aclk);
    awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_mid_wready%0d", i), wready, 1);
      wdata = wd[i]; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
      @(negedge aclk);
    end
    wdata = wd[2];
    #2 arst = 1'b0;
    #1 check("rst_mid_async_clear", {awready, wready, bvalid}, 3'b0);
    wvalid = 1'b0;
    @(negedge aclk);
    arst = 1'b1;
    #1 check("rst_mid_release_low", awready, 0);
    seen_b = 1'b0;
    @(negedge aclk);
    check("rst_mid_awready_back", awready, 1);
    repeat (4) begin
      if (bvalid) seen_b = 1'b1;
      @(negedge aclk);
    end
    check("rst_mid_no_bresp", seen_b, 0);
    do_read(16'h0070, 1, INCR, -1);
    check("rst_mid_kept_beat0", rd_data[0], 32'hE0);
    check("rst_mid_kept_beat1", rd_data[1], 32'hE1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
